ufifo_txseq: RTL and testbench

Transmit sequencer between a ufifo (BW=8) and a UART transmitter core. It pops one byte at a time from the FIFO and presents it to the transmitter with a strobe/busy handshake. It enforces a programmable inter-character gap and optionally gates on hardware flow control. It sits in the wbuart32 TX path and replaces ad-hoc glue between the TX FIFO and the transmitter.

---
 rtl/ufifo_txseq.sv | 113 +++++++++++
 tb/tb_ufifo_txseq.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ufifo_txseq.sv
// Transmit sequencer: pops bytes from a ufifo and hands them to a UART TX core,
// with a programmable inter-character gap. Define UFIFO_TXSEQ_CTS_EN for CTS gating.
module ufifo_txseq #(
  parameter int BW  = 8,
  parameter int GAP = 0
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_en,
  input  logic          i_fifo_empty_n,
  input  logic [BW-1:0] i_fifo_data,
  output logic          o_fifo_rd,
  output logic          o_tx_stb,
  output logic [BW-1:0] o_tx_data,
  input  logic          i_tx_busy,
`ifdef UFIFO_TXSEQ_CTS_EN
  input  logic          i_cts_n,
`endif
  output logic          o_active,
  output logic [15:0]   o_sent
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  localparam logic [15:0] GAP_LOAD = (GAP > 0) ? 16'(GAP - 1) : 16'd0;

  state_t      state;
  logic [15:0] gap_cnt;
  logic        cts_ok;

`ifdef UFIFO_TXSEQ_CTS_EN
  // Synchronizer resets to "not clear to send" so nothing is popped until CTS is seen low.
  logic [1:0] cts_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) cts_sync <= 2'b11;
    else       cts_sync <= {cts_sync[0], i_cts_n};
  end

  assign cts_ok = ~cts_sync[1];
`else
  assign cts_ok = 1'b1;
`endif

  // NOTE: all state and outputs update with non-blocking assignments in one
  // clocked block; blocking ones here would create ordering races in simulation.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= S_IDLE;
      gap_cnt   <= 16'd0;
      o_fifo_rd <= 1'b0;
      o_tx_stb  <= 1'b0;
      o_tx_data <= '0;
      o_active  <= 1'b0;
      o_sent    <= 16'd0;
    end else begin
      case (state)
        S_IDLE: begin
          o_fifo_rd <= 1'b0;
          o_tx_stb  <= 1'b0;
          if (i_en && i_fifo_empty_n && cts_ok) begin
            o_tx_data <= i_fifo_data;
            o_fifo_rd <= 1'b1;
            o_tx_stb  <= 1'b1;
            o_active  <= 1'b1;
            state     <= S_SEND;
          end
        end

        S_SEND: begin
          o_fifo_rd <= 1'b0;
          if (o_tx_stb) begin
            if (!i_tx_busy) begin
              o_tx_stb <= 1'b0;
              o_sent   <= o_sent + 16'd1;
            end
          end else begin
            // One settling cycle after the transfer lets the FIFO flags catch up
            // with the pop before the next IDLE decision.
            if (GAP > 0) begin
              gap_cnt <= GAP_LOAD;
              state   <= S_GAP;
            end else begin
              o_active <= 1'b0;
              state    <= S_IDLE;
            end
          end
        end

        S_GAP: begin
          if (gap_cnt == 16'd0) begin
            o_active <= 1'b0;
            state    <= S_IDLE;
          end else begin
            gap_cnt <= gap_cnt - 16'd1;
          end
        end

        default: begin
          o_fifo_rd <= 1'b0;
          o_tx_stb  <= 1'b0;
          o_active  <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ufifo_txseq.sv
// Directed bench for ufifo_txseq: one GAP=0 and one GAP=5 instance, each fed by a
// small FIFO model; CTS checks are compiled in when UFIFO_TXSEQ_CTS_EN is defined.
module tb_ufifo_txseq;

  logic        clk = 1'b0;
  logic        rst, en, busy;
`ifdef UFIFO_TXSEQ_CTS_EN
  logic        cts_n;
`endif

  logic        a_empty_n, a_rd, a_stb, a_active;
  logic [7:0]  a_data, a_txd;
  logic [15:0] a_sent;
  logic        b_empty_n, b_rd, b_stb, b_active;
  logic [7:0]  b_data, b_txd;
  logic [15:0] b_sent;

  ufifo_txseq #(.BW(8), .GAP(0)) u_dut (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .i_fifo_empty_n(a_empty_n), .i_fifo_data(a_data), .o_fifo_rd(a_rd),
    .o_tx_stb(a_stb), .o_tx_data(a_txd), .i_tx_busy(busy),
`ifdef UFIFO_TXSEQ_CTS_EN
    .i_cts_n(cts_n),
`endif
    .o_active(a_active), .o_sent(a_sent)
  );

  ufifo_txseq #(.BW(8), .GAP(5)) u_gap (
    .i_clk(clk), .i_rst(rst), .i_en(en),
    .i_fifo_empty_n(b_empty_n), .i_fifo_data(b_data), .o_fifo_rd(b_rd),
    .o_tx_stb(b_stb), .o_tx_data(b_txd), .i_tx_busy(busy),
`ifdef UFIFO_TXSEQ_CTS_EN
    .i_cts_n(cts_n),
`endif
    .o_active(b_active), .o_sent(b_sent)
  );

  always #5 clk = ~clk;

  int         n_tests = 0;
  int         n_fail  = 0;
  int         cyc     = 0;
  logic [7:0] qa[$], qb[$];    // FIFO contents
  logic [7:0] la[$], lb[$];    // bytes accepted by the transmitter
  int         ra_t[$], rb_t[$]; // cycles at which a read pulse was seen

  typedef struct {
    logic        en;
    logic        busy;
    logic        rd;
    logic        stb;
    logic [7:0]  txd;
    logic        act;
    logic [15:0] sent;
  } vec_t;
  vec_t tbl[11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fifo_drive();
    a_empty_n = (qa.size() != 0);
    a_data    = a_empty_n ? qa[0] : 8'h00;
    b_empty_n = (qb.size() != 0);
    b_data    = b_empty_n ? qb[0] : 8'h00;
  endtask

  // One clock: log transfers seen at the edge, then model the FIFO pop.
  task automatic tick();
    logic       xa, xb, ea, eb;
    logic [7:0] da, db;
    xa = (a_stb === 1'b1) && (busy === 1'b0) && (rst === 1'b0);
    xb = (b_stb === 1'b1) && (busy === 1'b0) && (rst === 1'b0);
    ea = a_empty_n;
    eb = b_empty_n;
    da = a_txd;
    db = b_txd;
    @(posedge clk);
    #1;
    cyc++;
    if (xa) la.push_back(da);
    if (xb) lb.push_back(db);
    if (a_rd === 1'b1) begin
      check("a_rd_nonempty", 32'(ea), 32'd1);
      ra_t.push_back(cyc);
      if (qa.size() != 0) void'(qa.pop_front());
    end
    if (b_rd === 1'b1) begin
      check("b_rd_nonempty", 32'(eb), 32'd1);
      rb_t.push_back(cyc);
      if (qb.size() != 0) void'(qb.pop_front());
    end
    fifo_drive();
  endtask

  initial begin
    // Three bytes, GAP=0, no back-pressure: one character every 3 clocks.
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h41, 1'b1, 16'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h41, 1'b1, 16'd1};
    tbl[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h41, 1'b0, 16'd1};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h42, 1'b1, 16'd1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h42, 1'b1, 16'd2};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h42, 1'b0, 16'd2};
    tbl[6]  = '{1'b1, 1'b0, 1'b1, 1'b1, 8'h43, 1'b1, 16'd2};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h43, 1'b1, 16'd3};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h43, 1'b0, 16'd3};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h43, 1'b0, 16'd3};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 8'h43, 1'b0, 16'd3};

    rst = 1'b1; en = 1'b0; busy = 1'b0;
`ifdef UFIFO_TXSEQ_CTS_EN
    cts_n = 1'b0;
`endif
    fifo_drive();
    tick(); tick();
    check("rst_rd",     32'(a_rd), 32'd0);
    check("rst_stb",    32'(a_stb), 32'd0);
    check("rst_txd",    32'(a_txd), 32'd0);
    check("rst_active", 32'(a_active), 32'd0);
    check("rst_sent",   32'(a_sent), 32'd0);
    check("rst_b_sent", 32'(b_sent), 32'd0);

    rst = 1'b0;
    tick(); tick(); tick();
    check("idle_empty_rd", 32'(a_rd), 32'd0);

    // Table-driven basic sequence.
    qa.push_back(8'h41); qa.push_back(8'h42); qa.push_back(8'h43);
    fifo_drive();
    ra_t.delete();
    for (int i = 0; i < 11; i++) begin
      en   = tbl[i].en;
      busy = tbl[i].busy;
      tick();
      check($sformatf("t%0d_rd", i),     32'(a_rd),     32'(tbl[i].rd));
      check($sformatf("t%0d_stb", i),    32'(a_stb),    32'(tbl[i].stb));
      check($sformatf("t%0d_txd", i),    32'(a_txd),    32'(tbl[i].txd));
      check($sformatf("t%0d_active", i), 32'(a_active), 32'(tbl[i].act));
      check($sformatf("t%0d_sent", i),   32'(a_sent),   32'(tbl[i].sent));
    end
    check("basic_rd_count", 32'(ra_t.size()), 32'd3);
    if (ra_t.size() == 3) begin
      check("basic_rd_space1", 32'(ra_t[1] - ra_t[0]), 32'd3);
      check("basic_rd_space2", 32'(ra_t[2] - ra_t[1]), 32'd3);
    end
    check("basic_log_size", 32'(la.size()), 32'd3);
    if (la.size() == 3) begin
      check("basic_byte0", 32'(la[0]), 32'h41);
      check("basic_byte1", 32'(la[1]), 32'h42);
      check("basic_byte2", 32'(la[2]), 32'h43);
    end

    // Transmitter busy for 20 clocks after the strobe rises.
    ra_t.delete();
    busy = 1'b1;
    qa.push_back(8'h41);
    fifo_drive();
    tick();
    check("busy_stb_rise", 32'(a_stb), 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("busy_stb_hold", 32'(a_stb), 32'd1);
      check("busy_txd_hold", 32'(a_txd), 32'h41);
      check("busy_rd_low", 32'(a_rd), 32'd0);
    end
    check("busy_sent_held", 32'(a_sent), 32'd3);
    busy = 1'b0;
    tick();
    check("busy_xfer_stb", 32'(a_stb), 32'd0);
    check("busy_xfer_sent", 32'(a_sent), 32'd4);
    tick(); tick();
    check("busy_rd_count", 32'(ra_t.size()), 32'd1);
    check("busy_idle", 32'(a_active), 32'd0);

    // GAP=5 instance with two bytes queued.
    rb_t.delete();
    qb.push_back(8'h51); qb.push_back(8'h52);
    fifo_drive();
    for (int t = 1; t <= 9; t++) begin
      tick();
      check($sformatf("gap_t%0d_rd", t), 32'(b_rd), 32'((t == 1) || (t == 9)));
      check($sformatf("gap_t%0d_active", t), 32'(b_active), 32'(t != 8));
    end
    check("gap_sent_mid", 32'(b_sent), 32'd1);
    for (int t = 0; t < 12; t++) tick();
    check("gap_rd_count", 32'(rb_t.size()), 32'd2);
    if (rb_t.size() == 2) check("gap_rd_space", 32'(rb_t[1] - rb_t[0]), 32'd8);
    check("gap_sent_end", 32'(b_sent), 32'd2);
    check("gap_active_end", 32'(b_active), 32'd0);
    check("gap_log_size", 32'(lb.size()), 32'd2);
    if (lb.size() == 2) begin
      check("gap_byte0", 32'(lb[0]), 32'h51);
      check("gap_byte1", 32'(lb[1]), 32'h52);
    end

    // Enable dropped one clock into SEND with four bytes queued.
    ra_t.delete();
    for (int i = 0; i < 4; i++) qa.push_back(8'h61 + 8'(i));
    fifo_drive();
    tick();
    check("en_first_rd", 32'(a_rd), 32'd1);
    en = 1'b0;
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("en_off_rd", 32'(a_rd), 32'd0);
    end
    check("en_off_sent", 32'(a_sent), 32'd5);
    check("en_off_rd_count", 32'(ra_t.size()), 32'd1);
    en = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("en_on_sent", 32'(a_sent), 32'd8);
    check("en_log_size", 32'(la.size()), 32'd8);
    if (la.size() == 8) begin
      for (int i = 0; i < 4; i++)
        check($sformatf("en_byte%0d", i), 32'(la[4+i]), 32'h61 + 32'(i));
    end

    // Reset while a popped byte is waiting on a busy transmitter.
    busy = 1'b1;
    qa.push_back(8'h71);
    fifo_drive();
    tick();
    check("rsend_stb", 32'(a_stb), 32'd1);
    rst = 1'b1;
    tick();
    check("rsend_stb_clr", 32'(a_stb), 32'd0);
    check("rsend_rd_clr", 32'(a_rd), 32'd0);
    check("rsend_sent_clr", 32'(a_sent), 32'd0);
    check("rsend_active_clr", 32'(a_active), 32'd0);
    rst = 1'b0;
    busy = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("rsend_discarded", 32'(la.size()), 32'd8);
    check("rsend_stb_idle", 32'(a_stb), 32'd0);

`ifdef UFIFO_TXSEQ_CTS_EN
    // CTS gating: blocked while high, 3-clock latency once low, no abort mid-character.
    ra_t.delete();
    cts_n = 1'b1;
    tick(); tick();
    qa.push_back(8'h81); qa.push_back(8'h82);
    fifo_drive();
    for (int i = 0; i < 5; i++) begin
      tick();
      check("cts_blocked_rd", 32'(a_rd), 32'd0);
    end
    cts_n = 1'b0;
    tick(); check("cts_lat1_rd", 32'(a_rd), 32'd0);
    tick(); check("cts_lat2_rd", 32'(a_rd), 32'd0);
    tick(); check("cts_lat3_rd", 32'(a_rd), 32'd1);
    cts_n = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    check("cts_rd_count", 32'(ra_t.size()), 32'd1);
    check("cts_sent", 32'(a_sent), 32'd1);
    check("cts_log_size", 32'(la.size()), 32'd9);
    if (la.size() == 9) check("cts_byte", 32'(la[8]), 32'h81);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
